// File: rtl/alu_seq_tester_if.sv
// alu_seq_tester_if -- bundle between the ALU sequencer, the board-level
// top and the ALU under test.
//   master : sequencer side. Drives ta/tb/op to the ALU plus run status
//            (busy, done, pass, err_cnt, vec_idx, mismatch); receives start
//            and the ALU results dut_f/dut_zf/dut_of.
//   slave  : board/ALU side, the mirror image.
// WIDTH is the operand/result width and must match the sequencer's WIDTH.
interface alu_seq_tester_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dut_f;
    logic             dut_zf;
    logic             dut_of;
    logic [WIDTH-1:0] ta;
    logic [WIDTH-1:0] tb;
    logic [2:0]       op;
    logic             busy;
    logic             done;
    logic             pass;
    logic [6:0]       err_cnt;
    logic [5:0]       vec_idx;
    logic             mismatch;

    modport master (
        input  start, dut_f, dut_zf, dut_of,
        output ta, tb, op, busy, done, pass, err_cnt, vec_idx, mismatch
    );

    modport slave (
        output start, dut_f, dut_zf, dut_of,
        input  ta, tb, op, busy, done, pass, err_cnt, vec_idx, mismatch
    );
endinterface

// File: rtl/alu_seq_tester.sv
// alu_seq_tester -- self-checking stimulus sequencer for the multifunction ALU.
// Walks all 64 vectors {opcode, pattern}, drives each one for SETTLE_CYC+2
// cycles, samples F/ZF/OF in the last cycle and compares them against an
// internal golden ALU, counting mismatching vectors.
// Parameters: WIDTH (8..64, multiple of 8), SETTLE_CYC (0..15).
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    alu_seq_tester_if.master (start in, ALU results in, operands and
//          run status out)
// Build option: define ALU_SEQ_HALT_ON_ERR_EN to stop the run at the first
// mismatching vector, leaving that vector on ta/tb/op/vec_idx for probing.
module alu_seq_tester #(
    parameter int WIDTH      = 32,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_tester_if.master bus
);
    localparam int               SHW         = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB         = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES        = '1;
    localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;

    // Operand pair {A, B} for pattern p. 32-bit constants are replicated to
    // 64 bits and then truncated, which gives R(x) for every legal WIDTH.
    function automatic logic [2*WIDTH-1:0] pattern(input logic [2:0] p);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        case (p)
            3'd0:    begin a = '0;   b = '0;   end
            3'd1:    begin a = WIDTH'(3); b = WIDTH'(16'h0607); end
            3'd2:    begin a = MSB;  b = MSB;  end
            3'd3:    begin a = ~MSB; b = ~MSB; end
            3'd4:    begin a = ONES; b = ONES; end
            3'd5:    begin a = MSB;  b = ONES; end
            3'd6:    begin a = WIDTH'({2{32'h1234_5678}}); b = WIDTH'({2{32'h3333_2222}}); end
            default: begin a = WIDTH'({2{32'h9ABC_DEF0}}); b = WIDTH'({2{32'h1111_2222}}); end
        endcase
        return {a, b};
    endfunction

    // Reference ALU, returns {OF, ZF, F}. OF is only defined for ADD/SUB.
    function automatic logic [WIDTH+1:0] golden(input logic [2:0] o,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] f;
        logic             of;
        f  = '0;
        of = 1'b0;
        case (o)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~(a | b);
            3'd4: begin
                f  = a + b;
                of = (a[WIDTH-1] == b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
            end
            3'd5: begin
                f  = a - b;
                of = (a[WIDTH-1] != b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
            end
            3'd6:    f = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: f = b << a[SHW-1:0];
        endcase
        return {of, (f == '0), f};
    endfunction

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] ta, ta_nxt, tb, tb_nxt;
    logic [2:0]       op, op_nxt;
    logic             busy, busy_nxt, done, done_nxt, pass, pass_nxt;
    logic [6:0]       err, err_nxt;
    logic [5:0]       vec, vec_nxt;
    logic             mm, mm_nxt;

    logic             fail;
    logic [5:0]       vec_inc;
    logic [6:0]       err_inc;

    assign fail    = golden(op, ta, tb) != {bus.dut_of, bus.dut_zf, bus.dut_f};
    assign vec_inc = vec + 6'd1;
    assign err_inc = (err == 7'd64) ? err : err + 7'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            ta    <= '0;
            tb    <= '0;
            op    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
            err   <= '0;
            vec   <= '0;
            mm    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ta    <= ta_nxt;
            tb    <= tb_nxt;
            op    <= op_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            pass  <= pass_nxt;
            err   <= err_nxt;
            vec   <= vec_nxt;
            mm    <= mm_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ta_nxt    = ta;
        tb_nxt    = tb;
        op_nxt    = op;
        busy_nxt  = busy;
        done_nxt  = done;
        pass_nxt  = pass;
        err_nxt   = err;
        vec_nxt   = vec;
        mm_nxt    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    // Operands for vector 0 are loaded on the way into APPLY.
                    state_nxt        = S_APPLY;
                    vec_nxt          = '0;
                    {ta_nxt, tb_nxt} = pattern(3'd0);
                    op_nxt           = 3'd0;
                    busy_nxt         = 1'b1;
                    done_nxt         = 1'b0;
                    pass_nxt         = 1'b0;
                    err_nxt          = '0;
                end
            end
            S_APPLY: begin
                cnt_nxt   = '0;
                state_nxt = (SETTLE_CYC == 0) ? S_CHECK : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) state_nxt = S_CHECK;
                else                    cnt_nxt   = cnt + 4'd1;
            end
            S_CHECK: begin
                mm_nxt = fail;
                if (fail) err_nxt = err_inc;
`ifdef ALU_SEQ_HALT_ON_ERR_EN
                if (fail || vec == 6'd63) begin
`else
                if (vec == 6'd63) begin
`endif
                    // ta/tb/op/vec stay on the final (or failing) vector.
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = !fail && (err == '0);
                end else begin
                    state_nxt        = S_APPLY;
                    vec_nxt          = vec_inc;
                    {ta_nxt, tb_nxt} = pattern(vec_inc[2:0]);
                    op_nxt           = vec_inc[5:3];
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.ta       = ta;
    assign bus.tb       = tb;
    assign bus.op       = op;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.pass     = pass;
    assign bus.err_cnt  = err;
    assign bus.vec_idx  = vec;
    assign bus.mismatch = mm;
endmodule

// File: tb/tb_alu_seq_tester.sv
// tb_alu_seq_tester -- bench for alu_seq_tester. Two instances (32-bit with
// SETTLE_CYC=2, 16-bit with SETTLE_CYC=0) each face a bench ALU that can be
// correct, have OF stuck at 0, or flip one result bit on a random subset of
// vectors. A timeline model (cycles since the accepted START) predicts every
// output on every cycle; a few literal expectations pin the model.
// Honours ALU_SEQ_HALT_ON_ERR_EN the same way as the design.
module tb_alu_seq_tester;
    localparam int W0 = 32, S0 = 2, W1 = 16, S1 = 0;
`ifdef ALU_SEQ_HALT_ON_ERR_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_seq_tester_if #(.WIDTH(W0)) bus0();
    alu_seq_tester_if #(.WIDTH(W1)) bus1();

    alu_seq_tester #(.WIDTH(W0), .SETTLE_CYC(S0)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    alu_seq_tester #(.WIDTH(W1), .SETTLE_CYC(S1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_chk = 0;
    int n_pass = 0;
    int mm0 = 0;
    int mm1 = 0;

    // Bench ALU fault controls, per instance: 0 good, 1 OF stuck 0, 2 flip bit fbit on flagged vectors
    int          mode[2] = '{0, 0};
    logic [63:0] flip[2] = '{64'd0, 64'd0};
    int          fbit[2] = '{0, 0};

    function automatic int wd(input int i);
        return (i == 0) ? W0 : W1;
    endfunction
    function automatic int pp(input int i);
        return (i == 0) ? S0 + 2 : S1 + 2;
    endfunction
    function automatic logic [63:0] wmask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // {A, B} of pattern p at width w
    function automatic logic [127:0] pat(input int w, input int p);
        logic [63:0] m, msb, a, b;
        m   = wmask(w);
        msb = 64'd1 << (w - 1);
        case (p)
            0: begin a = 0; b = 0; end
            1: begin a = 3; b = 64'h0607; end
            2: begin a = msb; b = msb; end
            3: begin a = ~msb; b = ~msb; end
            4: begin a = '1; b = '1; end
            5: begin a = msb; b = '1; end
            6: begin a = {2{32'h12345678}}; b = {2{32'h33332222}}; end
            default: begin a = {2{32'h9ABCDEF0}}; b = {2{32'h11112222}}; end
        endcase
        return {a & m, b & m};
    endfunction

    // {OF, ZF, F[63:0]} of the reference ALU at width w
    function automatic logic [65:0] galu(input int w, input logic [2:0] o,
                                         input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m, f, xa, xb;
        logic        of;
        int          lg;
        m  = wmask(w);
        of = 1'b0;
        lg = 0;
        while ((1 << lg) < w) lg++;
        xa = a[w-1] ? (a | ~m) : a;
        xb = b[w-1] ? (b | ~m) : b;
        case (o)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~(a | b) & m;
            3'd4: begin f = (a + b) & m; of = (a[w-1] == b[w-1]) && (f[w-1] != a[w-1]); end
            3'd5: begin f = (a - b) & m; of = (a[w-1] != b[w-1]) && (f[w-1] != a[w-1]); end
            3'd6: f = ($signed(xa) < $signed(xb)) ? 64'd1 : 64'd0;
            default: f = (b << (a & ((64'd1 << lg) - 64'd1))) & m;
        endcase
        return {of, (f == 0), f};
    endfunction

    function automatic logic [65:0] gvec(input int w, input int v);
        logic [127:0] ab;
        ab = pat(w, v % 8);
        return galu(w, 3'(v / 8), ab[127:64], ab[63:0]);
    endfunction

    function automatic logic [63:0] of_set(input int w);
        logic [63:0] s;
        logic [65:0] r;
        s = 0;
        for (int v = 0; v < 64; v++) begin
            r    = gvec(w, v);
            s[v] = r[65];
        end
        return s;
    endfunction

    // Which vectors the bench ALU currently gets wrong
    function automatic logic [63:0] fault_set(input int i);
        if (mode[i] == 1) return of_set(wd(i));
        if (mode[i] == 2) return flip[i];
        return 64'd0;
    endfunction

    function automatic int end_k(input int i, input logic [63:0] fs);
        if (HALT) for (int v = 0; v < 64; v++) if (fs[v]) return (v + 1) * pp(i);
        return 64 * pp(i);
    endfunction

    // Bench ALUs
    logic [65:0] r0, r1;
    always_comb begin
        r0 = galu(W0, bus0.op, 64'(bus0.ta), 64'(bus0.tb));
        if (mode[0] == 1) r0[65] = 1'b0;
        else if (mode[0] == 2 && flip[0][bus0.vec_idx]) r0 = r0 ^ (66'd1 << fbit[0]);
        bus0.dut_f  = r0[W0-1:0];
        bus0.dut_zf = r0[64];
        bus0.dut_of = r0[65];
    end
    always_comb begin
        r1 = galu(W1, bus1.op, 64'(bus1.ta), 64'(bus1.tb));
        if (mode[1] == 1) r1[65] = 1'b0;
        else if (mode[1] == 2 && flip[1][bus1.vec_idx]) r1 = r1 ^ (66'd1 << fbit[1]);
        bus1.dut_f  = r1[W1-1:0];
        bus1.dut_zf = r1[64];
        bus1.dut_of = r1[65];
    end

    // Timeline model: kk = clock edges since the accepted START (-1 = never started / reset)
    int          kk[2] = '{-1, -1};
    int          ek[2] = '{0, 0};
    logic [63:0] fsnap[2] = '{64'd0, 64'd0};

    function automatic logic st(input int i);
        return (i == 0) ? bus0.start : bus1.start;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kk[0] <= -1;
            kk[1] <= -1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (st(i) && !(kk[i] >= 0 && kk[i] < ek[i])) begin
                    fsnap[i] <= fault_set(i);
                    ek[i]    <= end_k(i, fault_set(i));
                    kk[i]    <= 0;
                end else if (kk[i] >= 0 && kk[i] <= ek[i]) begin
                    kk[i] <= kk[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cmp(input int i, input logic [63:0] ta, input logic [63:0] tb, input logic [2:0] op,
                       input logic busy, input logic done, input logic pass,
                       input logic [6:0] err, input logic [5:0] vi, input logic mm);
        logic [127:0] ab;
        logic [63:0]  ta_e, tb_e;
        logic [2:0]   op_e;
        logic         busy_e, done_e, pass_e, mm_e;
        int           err_e, vi_e, k, e, p, lim;
        k = kk[i]; e = ek[i]; p = pp(i);
        ta_e = 0; tb_e = 0; op_e = 0; busy_e = 0; done_e = 0; pass_e = 0; mm_e = 0;
        err_e = 0; vi_e = 0;
        if (k >= 0) begin
            vi_e   = (k < e) ? k / p : e / p - 1;
            ab     = pat(wd(i), vi_e % 8);
            ta_e   = ab[127:64];
            tb_e   = ab[63:0];
            op_e   = 3'(vi_e / 8);
            busy_e = k < e;
            done_e = !busy_e;
            lim    = (k < e) ? k : e;
            for (int v = 0; v < 64; v++) if (fsnap[i][v] && (v + 1) * p <= lim) err_e++;
            if (err_e > 64) err_e = 64;
            mm_e   = k > 0 && k <= e && (k % p) == 0 && fsnap[i][k/p-1];
            pass_e = done_e && err_e == 0;
        end
        n_chk++;
        if (ta === ta_e && tb === tb_e && op === op_e && busy === busy_e && done === done_e &&
            pass === pass_e && err === 7'(err_e) && vi === 6'(vi_e) && mm === mm_e)
            n_pass++;
        else
            $display("FAIL cycle_u%0d k=%0d: got ta=%h tb=%h op=%0d busy=%b done=%b pass=%b err=%0d vec=%0d mm=%b, expected ta=%h tb=%h op=%0d busy=%b done=%b pass=%b err=%0d vec=%0d mm=%b",
                     i, k, ta, tb, op, busy, done, pass, err, vi, mm,
                     ta_e, tb_e, op_e, busy_e, done_e, pass_e, err_e, vi_e, mm_e);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            cmp(0, 64'(bus0.ta), 64'(bus0.tb), bus0.op, bus0.busy, bus0.done, bus0.pass,
                bus0.err_cnt, bus0.vec_idx, bus0.mismatch);
            cmp(1, 64'(bus1.ta), 64'(bus1.tb), bus1.op, bus1.busy, bus1.done, bus1.pass,
                bus1.err_cnt, bus1.vec_idx, bus1.mismatch);
        end
    endtask

    task automatic mm_monitor();
        forever begin
            @(negedge clk);
            if (bus0.mismatch) mm0++;
            if (bus1.mismatch) mm1++;
        end
    endtask

    task automatic set_start(input int i, input logic v);
        if (i == 0) bus0.start = v;
        else        bus1.start = v;
    endtask

    function automatic logic dn(input int i);
        return (i == 0) ? bus0.done : bus1.done;
    endfunction

    task automatic start_pulse(input int i);
        @(negedge clk);
        set_start(i, 1'b1);
        @(posedge clk);
        #1;
        set_start(i, 1'b0);
    endtask

    // Edges until DONE is seen, sampled 1 time unit after each edge
    task automatic wait_done(input int i, input string name, output int n);
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (dn(i)) break;
            if (n >= 3000) begin
                chk({name, "_timeout"}, 64'(n), 64'd0);
                break;
            end
        end
    endtask

    int lat, m0, n, pick;

    initial begin
        fork
            compare_loop();
            mm_monitor();
        join_none
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus0.busy), 0);
        chk("rst_done", 64'(bus0.done), 0);
        chk("rst_ta", 64'(bus0.ta), 0);
        chk("rst_vec", 64'(bus0.vec_idx), 0);
        chk("rst_err", 64'(bus0.err_cnt), 0);
        rst_n = 1'b1;

        // pin the model itself
        chk("model_p6_a_w32", pat(32, 6) >> 64, 64'h12345678);
        chk("model_p6_b_w16", 64'(pat(16, 6)), 64'h2222);
        chk("model_of_vectors_w32", of_set(32), 64'h0000_002C_0000_0000);

        // clean full run, 32-bit
        mode[0] = 0;
        start_pulse(0);
        wait_done(0, "clean32", lat);
        chk("clean32_latency", 64'(lat), 256);
        chk("clean32_pass", 64'(bus0.pass), 1);
        chk("clean32_err", 64'(bus0.err_cnt), 0);
        chk("clean32_vec", 64'(bus0.vec_idx), 63);

        // OF stuck at 0
        mode[0] = 1;
        m0 = mm0;
        start_pulse(0);
        wait_done(0, "ofstuck", lat);
        chk("ofstuck_pass", 64'(bus0.pass), 0);
`ifdef ALU_SEQ_HALT_ON_ERR_EN
        chk("ofstuck_latency", 64'(lat), 140);
        chk("ofstuck_err", 64'(bus0.err_cnt), 1);
        chk("ofstuck_vec", 64'(bus0.vec_idx), 34);
        chk("ofstuck_ta", 64'(bus0.ta), 64'h80000000);
        chk("ofstuck_tb", 64'(bus0.tb), 64'h80000000);
        chk("ofstuck_op", 64'(bus0.op), 4);
`else
        chk("ofstuck_latency", 64'(lat), 256);
        chk("ofstuck_err", 64'(bus0.err_cnt), 3);
        chk("ofstuck_pulses", 64'(mm0 - m0), 3);
`endif

        // 16-bit, no settle window
        mode[1] = 0;
        start_pulse(1);
        wait_done(1, "clean16", lat);
        chk("clean16_latency", 64'(lat), 128);
        chk("clean16_pass", 64'(bus1.pass), 1);
        start_pulse(1);
        n = 0;
        while (bus1.vec_idx != 6'd6 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("p6_w16_ta", 64'(bus1.ta), 64'h5678);
        chk("p6_w16_tb", 64'(bus1.tb), 64'h2222);
        wait_done(1, "clean16b", lat);

        // randomized fault runs on either instance
        for (int r = 0; r < 6; r++) begin
            automatic int i = $urandom_range(0, 1);
            mode[i] = $urandom_range(0, 2);
            flip[i] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            pick = $urandom_range(0, wd(i) + 1);
            fbit[i] = (pick < wd(i)) ? pick : 64 + pick - wd(i);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start_pulse(i);
            wait_done(i, "rand", lat);
        end

        // reset in the middle of a run
        mode[0] = 0;
        start_pulse(0);
        n = 0;
        while (bus0.vec_idx != 6'd20 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus0.busy), 0);
        chk("midrst_vec", 64'(bus0.vec_idx), 0);
        chk("midrst_ta", 64'(bus0.ta), 0);
        chk("midrst_op", 64'(bus0.op), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_pulse(0);
        wait_done(0, "afterrst", lat);
        chk("afterrst_latency", 64'(lat), 256);
        chk("afterrst_err", 64'(bus0.err_cnt), 0);
        chk("afterrst_pass", 64'(bus0.pass), 1);

        // START held high: a START seen in DONE restarts from vector 0
        mode[0] = 1;
        @(negedge clk);
        bus0.start = 1'b1;
        wait_done(0, "held1", lat);
        @(posedge clk);
        #1;
        chk("held_restart_done", 64'(bus0.done), 0);
        chk("held_restart_busy", 64'(bus0.busy), 1);
        chk("held_restart_vec", 64'(bus0.vec_idx), 0);
        chk("held_restart_err", 64'(bus0.err_cnt), 0);
        wait_done(0, "held2", lat);
        chk("held2_latency", 64'(lat), HALT ? 140 : 256);
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_release_done", 64'(bus0.done), 1);
        chk("held_release_busy", 64'(bus0.busy), 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
